// File: rtl/rv32_lsu.sv
// RV32I load/store unit: one outstanding data-bus access with lane
// steering, load extension, misalignment/illegal-op and timeout errors.
module rv32_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    lo_q, lo_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [4:0]    rrd_q, rrd_d;
    logic          rerr_q, rerr_d;

    logic          legal;
    logic          aligned;
    logic [3:0]    lane_strb;
    logic [31:0]   lane_data;

    function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                             input logic [1:0]  lo,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lo, 3'b000});
        h = 16'(w >> {lo[1], 4'b0000});
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'b0, b};
            3'b101:  load_ext = {16'b0, h};
            default: load_ext = w;
        endcase
    endfunction

    always_comb begin
        if (req_is_store) begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010);
        end else begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                    (req_funct3 == 3'b101);
        end
        case (req_funct3[1:0])
            2'b01: begin
                aligned   = ~req_addr[0];
                lane_strb = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                aligned   = (req_addr[1:0] == 2'b00);
                lane_strb = 4'b1111;
                lane_data = req_wdata;
            end
            default: begin
                aligned   = 1'b1;
                lane_strb = 4'b0001 << req_addr[1:0];
                lane_data = {4{req_wdata[7:0]}};
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rrd_d   = rrd_q;
        rerr_d  = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d = req_is_store;
                    f3_d = req_funct3;
                    lo_d = req_addr[1:0];
                    rd_d = req_rd;
                    if (legal && aligned) begin
                        state_d = S_BUS;
                        cnt_d   = '0;
                        addr_d  = {req_addr[31:2], 2'b00};
                        wstrb_d = req_is_store ? lane_strb : 4'b0000;
                        wdata_d = req_is_store ? lane_data : 32'b0;
                    end else begin
                        // Rejected at accept: respond without touching the bus.
                        state_d = S_RESP;
                        rdata_d = '0;
                        rrd_d   = req_is_store ? 5'd0 : req_rd;
                        rerr_d  = 1'b1;
                    end
                end
            end
            S_BUS: begin
                if (mem_ready) begin
                    state_d = S_RESP;
                    rdata_d = we_q ? 32'b0 : load_ext(f3_q, lo_q, mem_rdata);
                    rrd_d   = we_q ? 5'd0 : rd_q;
                    rerr_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    rdata_d = '0;
                    rrd_d   = we_q ? 5'd0 : rd_q;
                    rerr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            lo_q    <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rrd_q   <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rrd_q   <= rrd_d;
            rerr_q  <= rerr_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign mem_valid  = (state_q == S_BUS);
    assign mem_we     = (state_q == S_BUS) && we_q;
    assign mem_addr   = addr_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_wdata  = wdata_q;
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = rdata_q;
    assign resp_rd    = rrd_q;
    assign resp_err   = rerr_q;

endmodule

// File: tb/tb_rv32_lsu.sv
// Randomized bench for rv32_lsu against a per-access behavioural model.
module tb_rv32_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    rv32_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          chk_en = 0, chk_bus = 0;
    logic        e_ready = 1, e_mv = 0, e_rv = 0, e_err = 0, e_we = 0;
    logic [31:0] e_data = 0, e_addr = 0, e_wdata = 0;
    logic [3:0]  e_strb = 0;
    logic [4:0]  e_rd = 0;

    logic [31:0] cap_data = 0, cap_wdata = 0, cap_addr = 0;
    logic [3:0]  cap_strb = 0;
    logic        cap_err = 0, cap_we = 0;
    int          resp_cyc = 0, acc_cyc = 0, mv_cnt = 0, rv_cnt = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    function automatic bit m_ok(bit st, bit [2:0] f3, bit [31:0] a);
        bit legal;
        legal = st ? (f3 < 3) : (f3 != 3 && f3 < 6);
        if (!legal) return 0;
        if (f3 % 4 == 1) return (a % 2 == 0);
        if (f3 % 4 == 2) return (a % 4 == 0);
        return 1;
    endfunction

    function automatic logic [3:0] m_strb(bit [2:0] f3, bit [31:0] a);
        if (f3 % 4 == 0) return 4'(1 << (a % 4));
        if (f3 % 4 == 1) return ((a / 2) % 2 == 1) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(bit [2:0] f3, bit [31:0] w);
        if (f3 % 4 == 0) return (w % 256) * 32'h0101_0101;
        if (f3 % 4 == 1) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(bit [2:0] f3, bit [31:0] a, bit [31:0] w);
        logic [31:0] v;
        if (f3 % 4 == 0) begin
            v = (w >> (8 * (a % 4))) % 256;
            if (f3 == 0 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (f3 % 4 == 1) begin
            v = (w >> (16 * ((a / 2) % 2))) % 65536;
            if (f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (mem_valid) begin
            mv_cnt++;
            cap_addr  = mem_addr;
            cap_strb  = mem_wstrb;
            cap_wdata = mem_wdata;
            cap_we    = mem_we;
        end
        if (resp_valid) begin
            rv_cnt++;
            resp_cyc = cyc;
            cap_data = resp_data;
            cap_err  = resp_err;
        end
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("mem_valid", 32'(mem_valid), 32'(e_mv));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("resp_data", resp_data, e_data);
            chk("resp_rd", 32'(resp_rd), 32'(e_rd));
            chk("resp_err", 32'(resp_err), 32'(e_err));
            if (chk_bus) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 0;
        e_ready = 1; e_mv = 0; e_rv = 0; chk_bus = 0;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom);
            step();
        end
    endtask

    task automatic access(input bit st, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] wd, input bit [4:0] rd,
                          input int dly, input bit [31:0] rdat);
        bit ok;
        ok = m_ok(st, f3, a);
        req_valid = 1; req_is_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = rd;
        mem_ready = 1'($urandom);
        e_ready = 1; e_mv = 0; e_rv = 0; chk_bus = 0;
        acc_cyc = cyc; mv_cnt = 0;
        step();
        req_valid = 1'($urandom); req_addr = $urandom; req_funct3 = 3'($urandom);
        if (ok) begin
            for (int i = 0; ; i++) begin
                e_ready = 0; e_mv = 1; chk_bus = 1;
                e_we = st; e_addr = a & 32'hFFFF_FFFC;
                e_strb = st ? m_strb(f3, a) : 4'd0;
                e_wdata = m_wdata(f3, wd);
                mem_ready = (i == dly);
                mem_rdata = (i == dly) ? rdat : $urandom;
                step();
                if (i == dly || i == T - 1) break;
            end
            chk_bus = 0; e_mv = 0; e_rv = 1;
            e_err = (dly >= T);
            e_data = (st || dly >= T) ? 32'd0 : m_load(f3, a, rdat);
            e_rd = st ? 5'd0 : rd;
        end else begin
            e_ready = 0; e_mv = 0; e_rv = 1;
            e_err = 1; e_data = 0; e_rd = st ? 5'd0 : rd;
        end
        mem_ready = 1'($urandom);
        step();
        req_valid = 0; e_rv = 0; e_ready = 1;
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_resp_data"}, resp_data, 32'd0);
        chk({tag, "_resp_rd"}, 32'(resp_rd), 32'd0);
    endtask

    initial begin
        int rv0;
        #3;
        reset_values("rst");
        #20 rst_n = 1;
        step();
        chk_en = 1;

        chk("pin_lb", m_load(3'b000, 32'h1003, 32'h80AB_CD12), 32'hFFFF_FF80);
        chk("pin_lhu", m_load(3'b101, 32'h2002, 32'h9234_5678), 32'h0000_9234);
        chk("pin_sb", m_wdata(3'b000, 32'h1234_56A5), 32'hA5A5_A5A5);

        access(0, 3'b000, 32'h1003, 0, 5'd7, 0, 32'h80AB_CD12);
        chk("t1_data", cap_data, 32'hFFFF_FF80);
        chk("t1_addr", cap_addr, 32'h0000_1000);
        chk("t1_strb", 32'(cap_strb), 32'd0);
        idle(1);
        access(0, 3'b101, 32'h2002, 0, 5'd9, 3, 32'h9234_5678);
        chk("t2_data", cap_data, 32'h0000_9234);
        chk("t2_latency", 32'(resp_cyc - acc_cyc), 32'd5);
        access(1, 3'b000, 32'h3001, 32'h1234_56A5, 5'd3, 1, 0);
        chk("t3_sb_strb", 32'(cap_strb), 32'b0010);
        chk("t3_sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        chk("t3_sb_we", 32'(cap_we), 32'd1);
        access(1, 3'b001, 32'h3002, 32'h0000_BEEF, 5'd3, 0, 0);
        chk("t3_sh_strb", 32'(cap_strb), 32'b1100);
        chk("t3_sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        access(0, 3'b010, 32'h4002, 0, 5'd4, 0, 0);
        chk("t4_mis_latency", 32'(resp_cyc - acc_cyc), 32'd1);
        chk("t4_mis_err", 32'(cap_err), 32'd1);
        chk("t4_mis_nobus", 32'(mv_cnt), 32'd0);
        access(0, 3'b011, 32'h4000, 0, 5'd4, 0, 0);
        chk("t4_ill_err", 32'(cap_err), 32'd1);
        chk("t4_ill_data", cap_data, 32'd0);
        access(0, 3'b010, 32'h5000, 0, 5'd5, 100, 0);
        chk("t5_to_cycles", 32'(mv_cnt), 32'd4);
        chk("t5_to_err", 32'(cap_err), 32'd1);
        access(0, 3'b010, 32'h5004, 0, 5'd5, 3, 32'hCAFE_F00D);
        chk("t5_last_cycles", 32'(mv_cnt), 32'd4);
        chk("t5_last_err", 32'(cap_err), 32'd0);
        chk("t5_last_data", cap_data, 32'hCAFE_F00D);

        // Reset while the bus access is still waiting.
        req_valid = 1; req_is_store = 0; req_funct3 = 3'b010;
        req_addr = 32'h6000; req_rd = 5'd11; mem_ready = 0;
        step();
        req_valid = 0;
        chk_en = 0;
        rv0 = rv_cnt;
        chk("t6_in_bus", 32'(mem_valid), 32'd1);
        #2 rst_n = 0;
        #1;
        reset_values("t6");
        step();
        step();
        rst_n = 1;
        step();
        chk("t6_no_resp", 32'(rv_cnt - rv0), 32'd0);
        e_data = 0; e_rd = 0; e_err = 0;
        chk_en = 1;
        idle(1);
        access(0, 3'b100, 32'h7001, 0, 5'd12, 1, 32'h0000_F300);
        chk("t6_after", cap_data, 32'h0000_00F3);

        for (int n = 0; n < 200; n++) begin
            bit st;
            bit [2:0] f3;
            bit [31:0] a;
            st = 1'($urandom);
            if ($urandom % 8 == 0) f3 = 3'($urandom);
            else if (st) f3 = 3'($urandom % 3);
            else begin
                f3 = 3'($urandom % 5);
                if (f3 == 3) f3 = 4;
                else if (f3 == 4) f3 = 5;
            end
            a = $urandom;
            if ($urandom % 5 != 0) begin
                if (f3 % 4 == 1) a = a & 32'hFFFF_FFFE;
                if (f3 % 4 == 2) a = a & 32'hFFFF_FFFC;
            end
            access(st, f3, a, $urandom, 5'($urandom), $urandom_range(0, 5), $urandom);
            idle($urandom_range(0, 2));
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
